// File: rtl/alu3_seq_if.sv
// Bus between the control unit (master) and the alu3_seq digit-serial sequencer (slave).
// Carries the operation request, the assembled result, its flags, and an FSM state debug view.
interface alu3_seq_if #(
    parameter int DIGITS = 4
);
    localparam int W = 3 * DIGITS;

    // start is accepted on a rising edge only while busy=0; busy is high for the
    // DIGITS cycles after an accepted start, and done pulses for one cycle when
    // result/c_out/zero/ovf have been updated. A start seen while busy is dropped.
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           nx;
    logic           ns;
    logic           n;
    logic           c_in;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           c_out;
    logic           zero;
    logic           ovf;
    logic [1:0]     state_dbg;

    modport master (
        output start, a, b, nx, ns, n, c_in,
        input  busy, done, result, c_out, zero, ovf, state_dbg
    );

    modport slave (
        input  start, a, b, nx, ns, n, c_in,
        output busy, done, result, c_out, zero, ovf, state_dbg
    );
endinterface

// File: rtl/alu3_seq.sv
// Digit-serial ALU sequencer: runs a W-bit op on one 3-bit CLA slice, LSB digit first.
// Optional signed-overflow flag is enabled by defining ALU3_SEQ_OVF_EN.
module alu3_seq #(
    parameter int DIGITS = 4
) (
    input  logic      clk,
    input  logic      reset,
    alu3_seq_if.slave bus
);
    localparam int W  = 3 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   shreg;
    logic [W-1:0]   result_r;
    logic           nx_r;
    logic           ns_r;
    logic           n_r;
    logic           carry;
    logic           busy_r;
    logic           done_r;
    logic           c_out_r;
    logic           zero_r;
    logic [CW-1:0]  cnt;

    logic [2:0]     a_d;
    logic [2:0]     b_d;
    logic [2:0]     p;
    logic [2:0]     g;
    logic [2:0]     q;
    logic           c0;
    logic           c1;
    logic           cout;
    logic [W-1:0]   next_result;

    // Operands are shifted right each RUN cycle so the active digit is always bits [2:0].
    assign a_d  = a_r[2:0] & {3{ns_r}};
    assign b_d  = b_r[2:0] & {3{n_r}};
    assign p    = a_d | b_d;
    assign g    = a_d & b_d & {3{nx_r}};
    assign c0   = g[0] | (p[0] & carry);
    assign c1   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign cout = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    assign q    = a_d ^ b_d ^ {c1, c0, carry};

    assign next_result = (shreg >> 3) | (W'(q) << (W - 3));

`ifdef ALU3_SEQ_OVF_EN
    logic ovf_r;
    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.c_out     = c_out_r;
    assign bus.zero      = zero_r;
    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            c_out_r  <= 1'b0;
            zero_r   <= 1'b1;
            cnt      <= '0;
            carry    <= 1'b0;
            shreg    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            nx_r     <= 1'b0;
            ns_r     <= 1'b0;
            n_r      <= 1'b0;
`ifdef ALU3_SEQ_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        nx_r   <= bus.nx;
                        ns_r   <= bus.ns;
                        n_r    <= bus.n;
                        carry  <= bus.c_in & bus.nx;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 3;
                    b_r   <= b_r >> 3;
                    shreg <= next_result;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    // Flags are only published here so they never expose partial digits.
                    if (cnt == LAST) begin
                        state    <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= next_result;
                        c_out_r  <= cout;
                        zero_r   <= (next_result == '0);
`ifdef ALU3_SEQ_OVF_EN
                        ovf_r    <= c1 ^ cout;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu3_seq.sv
// Self-checking bench for alu3_seq: directed ops, handshake corner cases and random ops
// compared against a whole-word arithmetic reference model.
module tb_alu3_seq;
    localparam int DIGITS = 4;
    localparam int W = 3 * DIGITS;

    typedef struct packed {
        logic [W-1:0] result;
        logic         c_out;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [W-1:0] exp_q[$];

    alu3_seq_if #(.DIGITS(DIGITS)) bus();

    alu3_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word add (or XOR when nx=0) on the masked operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic nx, input logic ns, input logic n, input logic cin);
        exp_t e;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic [W:0]   s;
        aa = ns ? a : '0;
        bb = n ? b : '0;
        if (nx) begin
            s = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cin};
            e.result = s[W-1:0];
            e.c_out  = s[W];
            e.ovf    = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
        end else begin
            e.result = aa ^ bb;
            e.c_out  = 1'b0;
            e.ovf    = 1'b0;
        end
        e.zero = (e.result == '0);
`ifndef ALU3_SEQ_OVF_EN
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Driver: called #1 after an edge; start is sampled at the next edge, and the
    // task returns #1 after that edge with non-start inputs scrambled.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic nx, input logic ns, input logic n, input logic cin);
        bus.a = a; bus.b = b; bus.nx = nx; bus.ns = ns; bus.n = n; bus.c_in = cin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.nx = 1'($urandom); bus.ns = 1'($urandom); bus.n = 1'($urandom); bus.c_in = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
        total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out got=%b want=0", bus.c_out); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", bus.zero); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    endtask

    task automatic test_add();
        drive_op(12'h123, 12'h456, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DIGITS; i++) begin
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL add_busy cyc=%0d got=%b want=1", i, bus.busy); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_early_done cyc=%0d got=%b want=0", i, bus.done); end
            @(posedge clk); #1;
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL add_done got=%b want=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_busy_end got=%b want=0", bus.busy); end
        total++; if (bus.result !== 12'h579) begin bad++; $display("FAIL add_result got=%h want=579", bus.result); end
        total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL add_c_out got=%b want=0", bus.c_out); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", bus.zero); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", bus.done); end
        total++; if (bus.result !== 12'h579) begin bad++; $display("FAIL add_hold got=%h want=579", bus.result); end
    endtask

    task automatic test_add_wrap();
        int lat;
        drive_op(12'hFFF, 12'h001, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        total++; if (lat != DIGITS) begin bad++; $display("FAIL wrap_latency got=%0d want=%0d", lat, DIGITS); end
        total++; if (bus.result !== 12'h000) begin bad++; $display("FAIL wrap_result got=%h want=000", bus.result); end
        total++; if (bus.c_out !== 1'b1) begin bad++; $display("FAIL wrap_c_out got=%b want=1", bus.c_out); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%b want=1", bus.zero); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", bus.ovf); end
    endtask

    task automatic test_xor();
        int lat;
        drive_op(12'hA5A, 12'h0FF, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_done(lat);
        total++; if (lat != DIGITS) begin bad++; $display("FAIL xor_latency got=%0d want=%0d", lat, DIGITS); end
        total++; if (bus.result !== 12'hAA5) begin bad++; $display("FAIL xor_result got=%h want=aa5", bus.result); end
        total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL xor_c_out got=%b want=0", bus.c_out); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL xor_ovf got=%b want=0", bus.ovf); end
    endtask

    task automatic test_increment();
        int lat;
        logic want_ovf;
`ifdef ALU3_SEQ_OVF_EN
        want_ovf = 1'b1;
`else
        want_ovf = 1'b0;
`endif
        drive_op(12'h7FF, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_done(lat);
        total++; if (lat != DIGITS) begin bad++; $display("FAIL inc_latency got=%0d want=%0d", lat, DIGITS); end
        total++; if (bus.result !== 12'h800) begin bad++; $display("FAIL inc_result got=%h want=800", bus.result); end
        total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL inc_c_out got=%b want=0", bus.c_out); end
        total++; if (bus.ovf !== want_ovf) begin bad++; $display("FAIL inc_ovf got=%b want=%b", bus.ovf, want_ovf); end
    endtask

    task automatic test_ignore_start();
        int dones;
        int done_at;
        logic [W-1:0] got;
        dones = 0; done_at = -1; got = '0;
        drive_op(12'h123, 12'h456, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.a = 12'hFFF; bus.b = 12'hFFF;
                bus.nx = 1'b1; bus.ns = 1'b1; bus.n = 1'b1; bus.c_in = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (done_at < 0) begin done_at = i; got = bus.result; end
            end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        total++; if (done_at != DIGITS) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", done_at, DIGITS); end
        total++; if (got !== 12'h579) begin bad++; $display("FAIL ignore_result got=%h want=579", got); end
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_op(12'h321, 12'h111, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(lat);
        total++; if (bus.result !== 12'h433) begin bad++; $display("FAIL b2b_first got=%h want=433", bus.result); end
        drive_op(12'h0F0, 12'h00F, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", bus.busy); end
        total++; if (bus.result !== 12'h433) begin bad++; $display("FAIL b2b_hold got=%h want=433", bus.result); end
        wait_done(lat);
        total++; if (lat != DIGITS) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, DIGITS); end
        total++; if (bus.result !== 12'h0FF) begin bad++; $display("FAIL b2b_second got=%h want=0ff", bus.result); end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        drive_op(12'h123, 12'h456, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", bus.done); end
        total++; if (bus.result !== '0) begin bad++; $display("FAIL abort_result got=%h want=0", bus.result); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL abort_zero got=%b want=1", bus.zero); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    endtask

    task automatic test_random();
        int lat;
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rnx, rns, rn, rcin;
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            if (k % 8 == 0) rb = ~ra;
            rnx = 1'($urandom_range(0, 3) != 0);
            rns = 1'($urandom_range(0, 4) != 0);
            rn  = 1'($urandom_range(0, 4) != 0);
            rcin = 1'($urandom);
            e = model(ra, rb, rnx, rns, rn, rcin);
            exp_q.push_back(e.result);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            drive_op(ra, rb, rnx, rns, rn, rcin);
            wait_done(lat);
            total++; if (lat != DIGITS) begin bad++; $display("FAIL rand_latency k=%0d got=%0d want=%0d", k, lat, DIGITS); end
            total++; if (bus.result !== exp_q.pop_front()) begin bad++; $display("FAIL rand_result k=%0d got=%h want=%h", k, bus.result, e.result); end
            total++; if (bus.c_out !== e.c_out) begin bad++; $display("FAIL rand_c_out k=%0d got=%b want=%b", k, bus.c_out, e.c_out); end
            total++; if (bus.zero !== e.zero) begin bad++; $display("FAIL rand_zero k=%0d got=%b want=%b", k, bus.zero, e.zero); end
            total++; if (bus.ovf !== e.ovf) begin bad++; $display("FAIL rand_ovf k=%0d got=%b want=%b", k, bus.ovf, e.ovf); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        bus.nx = 1'b0; bus.ns = 1'b0; bus.n = 1'b0; bus.c_in = 1'b0;
        test_reset();
        test_add();
        test_add_wrap();
        test_xor();
        test_increment();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
